// File: rtl/uart_rx_pkg.sv
// Shared widths, constants and helpers for the UART RX sampling stage.
package uart_rx_pkg;

  localparam int EDGE_W = 5;
  localparam int BIT_W  = 4;
  localparam logic [BIT_W-1:0] BIT_CNT_MAX = 4'd15;
  localparam logic RX_IDLE = 1'b1;
  localparam int MIN_PRESCALE_DEF = 4;

  function automatic logic [EDGE_W-1:0] clamp_prescale(
    input logic [EDGE_W-1:0] p,
    input logic [EDGE_W-1:0] floor_v
  );
    return (p < floor_v) ? floor_v : p;
  endfunction

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// RX line synchronizer; every stage resets to the idle level so the
// sampler never sees a false start bit coming out of reset.
module uart_rx_sync
  import uart_rx_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic CLK,
  input  logic RST,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      sync_q <= {SYNC_STAGES{RX_IDLE}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d};
    end
  end

  assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx_sampler.sv
// UART RX oversampling stage: per-bit edge/bit counters and a three-sample
// mid-bit majority voter, gated by the RX FSM's enable and dat_samp_en.
module uart_rx_sampler
  import uart_rx_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int MIN_PRESCALE = MIN_PRESCALE_DEF
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              RX_IN,
  input  logic [EDGE_W-1:0] Prescale,
  input  logic              enable,
  input  logic              dat_samp_en,
  output logic [EDGE_W-1:0] edge_cnt,
  output logic [BIT_W-1:0]  bit_cnt,
  output logic              sampled_bit,
  output logic              samp_valid
);

  localparam logic [EDGE_W-1:0] PRESC_FLOOR = EDGE_W'(MIN_PRESCALE);
  localparam logic [EDGE_W-1:0] ONE         = EDGE_W'(1);

  logic              rx_s;
  logic              enable_q;
  logic [EDGE_W-1:0] presc_q;
  logic [EDGE_W-1:0] presc_cur;
  logic [EDGE_W-1:0] mid;
  logic              last_edge;
  logic              samp_on;
  logic              cap0;
  logic              cap1;
  logic              cap2;
  logic              s0;
  logic              s1;
  logic              v0;
  logic              v1;

  uart_rx_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .CLK (CLK),
    .RST (RST),
    .d   (RX_IN),
    .q   (rx_s)
  );

  // On the enable rising edge the freshly clamped Prescale is used directly,
  // so the first bit of a frame already runs at the new ratio.
  always_comb begin
    presc_cur = (enable && !enable_q) ? clamp_prescale(Prescale, PRESC_FLOOR) : presc_q;
    mid       = presc_cur >> 1;
    last_edge = (edge_cnt == presc_cur - ONE);
    samp_on   = enable && dat_samp_en;
    cap0      = samp_on && (edge_cnt == mid - ONE);
    cap1      = samp_on && v0 && (edge_cnt == mid);
    cap2      = samp_on && v1 && (edge_cnt == mid + ONE);
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      enable_q <= 1'b0;
      presc_q  <= PRESC_FLOOR;
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else begin
      enable_q <= enable;
      if (enable) begin
        presc_q <= presc_cur;
        if (last_edge) begin
          edge_cnt <= '0;
          if (bit_cnt != BIT_CNT_MAX) begin
            bit_cnt <= bit_cnt + BIT_W'(1);
          end
        end else begin
          edge_cnt <= edge_cnt + ONE;
        end
      end else begin
        edge_cnt <= '0;
        bit_cnt  <= '0;
      end
    end
  end

  // v0/v1 mark a vote in progress; any gap in samp_on throws it away.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      s0          <= 1'b0;
      s1          <= 1'b0;
      v0          <= 1'b0;
      v1          <= 1'b0;
      sampled_bit <= RX_IDLE;
      samp_valid  <= 1'b0;
    end else begin
      samp_valid <= cap2;
      if (cap2) begin
        sampled_bit <= majority3(s0, s1, rx_s);
      end
      if (!samp_on || cap2) begin
        v0 <= 1'b0;
        v1 <= 1'b0;
      end else if (cap0) begin
        s0 <= rx_s;
        v0 <= 1'b1;
        v1 <= 1'b0;
      end else if (cap1) begin
        s1 <= rx_s;
        v1 <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Self-checking bench for uart_rx_sampler: directed table, corner sequences
// and randomized traffic against a cycle-count based reference model.
module tb_uart_rx_sampler;

  localparam int SYNC  = 2;
  localparam int MIN_P = 4;

  logic       CLK;
  logic       RST;
  logic       RX_IN;
  logic [4:0] Prescale;
  logic       enable;
  logic       dat_samp_en;
  logic [4:0] edge_cnt;
  logic [3:0] bit_cnt;
  logic       sampled_bit;
  logic       samp_valid;

  uart_rx_sampler #(
    .SYNC_STAGES (SYNC),
    .MIN_PRESCALE(MIN_P)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .RX_IN      (RX_IN),
    .Prescale   (Prescale),
    .enable     (enable),
    .dat_samp_en(dat_samp_en),
    .edge_cnt   (edge_cnt),
    .bit_cnt    (bit_cnt),
    .sampled_bit(sampled_bit),
    .samp_valid (samp_valid)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: position in the frame is just the count of enabled
  // clocks since enable rose; a vote needs three consecutive sampling clocks
  // ending at position mid+1 of a bit.
  int m_t;
  int m_p;
  bit m_pen;
  bit rx_pipe[$];
  bit ok_h[2];
  bit rx_h[2];
  int exp_edge;
  int exp_bit;
  int exp_sv;
  int exp_sb;

  task automatic model_step(input bit rst, input bit en, input bit dse, input bit rx,
                            input logic [4:0] presc);
    bit rxs;
    int e;
    int mid;
    int ones;
    if (!rst) begin
      m_t = 0;
      m_pen = 0;
      rx_pipe.delete();
      for (int i = 0; i < SYNC; i++) rx_pipe.push_back(1'b1);
      ok_h = '{0, 0};
      rx_h = '{0, 0};
      exp_edge = 0;
      exp_bit = 0;
      exp_sv = 0;
      exp_sb = 1;
      return;
    end
    rxs = rx_pipe.pop_front();
    rx_pipe.push_back(rx);
    exp_sv = 0;
    if (en) begin
      if (!m_pen) m_p = (int'(presc) < MIN_P) ? MIN_P : int'(presc);
      e = m_t % m_p;
      mid = m_p / 2;
      if (dse && e == mid + 1 && ok_h[0] && ok_h[1]) begin
        ones = int'(rxs) + int'(rx_h[0]) + int'(rx_h[1]);
        exp_sv = 1;
        exp_sb = (ones >= 2) ? 1 : 0;
      end
      m_t++;
      exp_edge = m_t % m_p;
      exp_bit = (m_t / m_p > 15) ? 15 : m_t / m_p;
    end else begin
      m_t = 0;
      exp_edge = 0;
      exp_bit = 0;
    end
    ok_h[1] = ok_h[0];
    rx_h[1] = rx_h[0];
    ok_h[0] = en && dse;
    rx_h[0] = rxs;
    m_pen = en;
  endtask

  task automatic step(input bit rst, input bit en, input bit dse, input bit rx,
                      input logic [4:0] presc);
    RST = rst;
    enable = en;
    dat_samp_en = dse;
    RX_IN = rx;
    Prescale = presc;
    model_step(rst, en, dse, rx, presc);
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic step_chk(input bit rst, input bit en, input bit dse, input bit rx,
                          input logic [4:0] presc);
    step(rst, en, dse, rx, presc);
    check("edge_cnt", int'(edge_cnt), exp_edge);
    check("bit_cnt", int'(bit_cnt), exp_bit);
    check("samp_valid", int'(samp_valid), exp_sv);
    check("sampled_bit", int'(sampled_bit), exp_sb);
  endtask

  typedef struct {
    bit         rst;
    bit         en;
    bit         dse;
    bit         rx;
    logic [4:0] presc;
    int         e_edge;
    int         e_bit;
    int         e_sv;
    int         e_sb;
  } vec_t;

  function automatic vec_t mk(input bit rst, input bit en, input bit dse, input bit rx,
                              input int presc, input int e_edge, input int e_bit,
                              input int e_sv, input int e_sb);
    vec_t v;
    v.rst = rst; v.en = en; v.dse = dse; v.rx = rx; v.presc = 5'(presc);
    v.e_edge = e_edge; v.e_bit = e_bit; v.e_sv = e_sv; v.e_sb = e_sb;
    return v;
  endfunction

  localparam int NVEC = 21;
  vec_t tbl[NVEC];

  bit pat[2][3] = '{'{1'b0, 1'b1, 1'b0}, '{1'b1, 1'b1, 1'b0}};

  function automatic bit want_rxs(input int t);
    int b;
    int e;
    b = t / 8;
    e = t % 8;
    if (b < 2 && e >= 3 && e <= 5) return pat[b][e-3];
    return 1'b1;
  endfunction

  int pulses;

  initial begin
    // rst en dse rx presc | edge bit sv sb
    tbl[0]  = mk(0, 1, 0, 0,  8, 0, 0, 0, 1);
    tbl[1]  = mk(0, 1, 0, 0,  8, 0, 0, 0, 1);
    tbl[2]  = mk(0, 1, 0, 0,  8, 0, 0, 0, 1);
    tbl[3]  = mk(1, 1, 0, 1,  2, 1, 0, 0, 1);
    tbl[4]  = mk(1, 1, 0, 1,  2, 2, 0, 0, 1);
    tbl[5]  = mk(1, 1, 0, 1,  2, 3, 0, 0, 1);
    tbl[6]  = mk(1, 1, 0, 1,  2, 0, 1, 0, 1);
    tbl[7]  = mk(1, 1, 0, 1, 16, 1, 1, 0, 1);
    tbl[8]  = mk(1, 1, 0, 1, 16, 2, 1, 0, 1);
    tbl[9]  = mk(1, 1, 0, 1, 16, 3, 1, 0, 1);
    tbl[10] = mk(1, 1, 0, 0, 16, 0, 2, 0, 1);
    tbl[11] = mk(1, 1, 1, 0, 16, 1, 2, 0, 1);
    tbl[12] = mk(1, 1, 1, 1, 16, 2, 2, 0, 1);
    tbl[13] = mk(1, 1, 1, 1, 16, 3, 2, 0, 1);
    tbl[14] = mk(1, 1, 1, 1, 16, 0, 3, 1, 0);
    tbl[15] = mk(1, 1, 1, 1, 16, 1, 3, 0, 0);
    tbl[16] = mk(1, 1, 1, 1, 16, 2, 3, 0, 0);
    tbl[17] = mk(1, 1, 1, 1, 16, 3, 3, 0, 0);
    tbl[18] = mk(1, 1, 1, 1, 16, 0, 4, 1, 1);
    tbl[19] = mk(1, 0, 0, 1, 16, 0, 0, 0, 1);
    tbl[20] = mk(1, 1, 0, 1, 16, 1, 0, 0, 1);

    RST = 1'b0; enable = 1'b0; dat_samp_en = 1'b0; RX_IN = 1'b1; Prescale = 5'd8;
    @(negedge CLK);

    // Directed table: reset, clamp, mid-frame Prescale change, votes at Prescale_eff=4.
    for (int i = 0; i < NVEC; i++) begin
      step(tbl[i].rst, tbl[i].en, tbl[i].dse, tbl[i].rx, tbl[i].presc);
      check($sformatf("tbl[%0d].edge_cnt", i), int'(edge_cnt), tbl[i].e_edge);
      check($sformatf("tbl[%0d].bit_cnt", i), int'(bit_cnt), tbl[i].e_bit);
      check($sformatf("tbl[%0d].samp_valid", i), int'(samp_valid), tbl[i].e_sv);
      check($sformatf("tbl[%0d].sampled_bit", i), int'(sampled_bit), tbl[i].e_sb);
    end

    // Counter wrap, Prescale=8, no sampling.
    step_chk(0, 0, 0, 1, 8);
    step_chk(1, 0, 0, 1, 8);
    pulses = 0;
    for (int t = 0; t < 40; t++) begin
      step_chk(1, 1, 0, 1, 8);
      if (samp_valid) pulses++;
    end
    check("wrap_bit_cnt", int'(bit_cnt), 5);
    check("wrap_edge_cnt", int'(edge_cnt), 0);
    check("wrap_no_pulse", pulses, 0);

    // Majority votes, Prescale=8: rx_s 0,1,0 then 1,1,0 at edge_cnt 3,4,5.
    step_chk(0, 0, 0, 1, 8);
    step_chk(1, 0, 0, 1, 8);
    pulses = 0;
    for (int t = 0; t < 16; t++) begin
      step_chk(1, 1, 1, want_rxs(t + SYNC), 8);
      if (samp_valid) begin
        pulses++;
        check("vote_edge", int'(edge_cnt), 6);
        check("vote_value", int'(sampled_bit), (t < 8) ? 0 : 1);
      end
    end
    check("vote_pulses", pulses, 2);

    // Abort by enable falling mid-vote.
    step_chk(0, 0, 0, 1, 8);
    step_chk(1, 0, 0, 1, 8);
    pulses = 0;
    for (int t = 0; t < 4; t++) step_chk(1, 1, 1, 0, 8);
    step_chk(1, 0, 1, 0, 8);
    check("abort_edge", int'(edge_cnt), 0);
    check("abort_bit", int'(bit_cnt), 0);
    for (int t = 0; t < 8; t++) begin
      step_chk(1, 0, 1, 0, 8);
      if (samp_valid) pulses++;
    end
    check("abort_no_pulse", pulses, 0);

    // Abort by dat_samp_en falling between s0 and s2.
    step_chk(1, 1, 1, 0, 8);
    pulses = 0;
    for (int t = 1; t < 4; t++) step_chk(1, 1, 1, 0, 8);
    for (int t = 4; t < 16; t++) begin
      step_chk(1, 1, 0, 0, 8);
      if (samp_valid) pulses++;
    end
    check("dse_abort_no_pulse", pulses, 0);

    // Saturation at Prescale_eff=4, then reset mid-operation.
    step_chk(0, 0, 0, 1, 4);
    step_chk(1, 0, 0, 1, 4);
    for (int t = 0; t < 70; t++) step_chk(1, 1, 1, t[0], 4);
    check("sat_bit_cnt", int'(bit_cnt), 15);
    step_chk(0, 1, 1, 0, 4);
    check("rst_edge", int'(edge_cnt), 0);
    check("rst_bit", int'(bit_cnt), 0);
    check("rst_valid", int'(samp_valid), 0);
    check("rst_sampled", int'(sampled_bit), 1);

    // Randomized traffic.
    begin
      bit r_en;
      bit r_dse;
      bit r_rst;
      logic [4:0] r_p;
      r_en = 1'b1;
      r_dse = 1'b1;
      r_p = 5'd8;
      for (int c = 0; c < 3000; c++) begin
        if ($urandom_range(39) == 0) r_en = ~r_en;
        if ($urandom_range(14) == 0) r_dse = ~r_dse;
        if ($urandom_range(24) == 0) r_p = 5'($urandom_range(31));
        r_rst = ($urandom_range(299) != 0);
        step_chk(r_rst, r_en, r_dse, 1'($urandom_range(1)), r_p);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
